carry_resolve: RTL and testbench



---
 rtl/carry_resolve_pkg.sv | 25 ++
 rtl/carry_resolve_column_adder.sv | 26 ++
 rtl/carry_resolve.sv | 149 ++++++++++++++
 tb/tb_carry_resolve.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/carry_resolve_pkg.sv
// Shared definitions for carry_resolve: FSM states and the width derivations
// kept identical to the column multiplier so both blocks agree on OUT_BIT_LEN.
package carry_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic int extra_tree_bits(input int num_elements);
    return $clog2(num_elements);
  endfunction

  // Column word width: partial-product width above one word plus adder-tree growth.
  function automatic int out_bit_len(input int a_bit_len, input int b_bit_len,
                                     input int word_len, input int num_elements);
    return a_bit_len + b_bit_len - word_len + extra_tree_bits(num_elements);
  endfunction

  function automatic int carry_len(input int out_bits, input int word_len);
    return out_bits + 2 - word_len;
  endfunction

endpackage

// File: rtl/carry_resolve_column_adder.sv
// Combinational column adder: Cout + S + carry_in split into one normalized
// word and the carry forwarded to the next column.
module column_adder #(
  parameter int OUT_BIT_LEN = 24,
  parameter int WORD_LEN    = 16,
  parameter int CARRY_LEN   = 10
) (
  input  logic [OUT_BIT_LEN-1:0] cout_i,
  input  logic [OUT_BIT_LEN-1:0] s_i,
  input  logic [CARRY_LEN-1:0]   carry_i,
  output logic [WORD_LEN-1:0]    word_o,
  output logic [CARRY_LEN-1:0]   carry_o
);

  localparam int SUM_W = OUT_BIT_LEN + 2;

  logic [SUM_W-1:0] sum_s;

  // CARRY_LEN equals SUM_W-WORD_LEN, so the upper slice fits the carry exactly.
  always_comb begin
    sum_s   = {2'b00, cout_i} + {2'b00, s_i} + SUM_W'(carry_i);
    word_o  = sum_s[WORD_LEN-1:0];
    carry_o = sum_s[SUM_W-1:WORD_LEN];
  end

endmodule

// File: rtl/carry_resolve.sv
// Sequential carry resolver: ripples Cout/S column carries into normalized
// WORD_LEN words, one column per cycle. Optional: CARRY_RESOLVE_OVERFLOW_EN.
module carry_resolve
  import carry_resolve_pkg::*;
#(
  parameter int NUM_ELEMENTS = 33,
  parameter int A_BIT_LEN    = 17,
  parameter int B_BIT_LEN    = 17,
  parameter int WORD_LEN     = 16,
  localparam int NUM_COLS    = 2 * NUM_ELEMENTS,
  localparam int OUT_BIT_LEN = out_bit_len(A_BIT_LEN, B_BIT_LEN, WORD_LEN, NUM_ELEMENTS),
  localparam int CARRY_LEN   = carry_len(OUT_BIT_LEN, WORD_LEN)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_COLS*OUT_BIT_LEN-1:0] Cout,
  input  logic [NUM_COLS*OUT_BIT_LEN-1:0] S,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_COLS*WORD_LEN-1:0]    Z,
  output logic                            overflow
);

  localparam int IDX_W = $clog2(NUM_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  state_e                          state_q, state_d;
  logic                            in_ready_q, in_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic [NUM_COLS*OUT_BIT_LEN-1:0] cout_q, cout_d;
  logic [NUM_COLS*OUT_BIT_LEN-1:0] s_q, s_d;
  logic [NUM_COLS*WORD_LEN-1:0]    z_q, z_d;
  logic [CARRY_LEN-1:0]            carry_q, carry_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [WORD_LEN-1:0]             col_word_s;
  logic [CARRY_LEN-1:0]            col_carry_s;
`ifdef CARRY_RESOLVE_OVERFLOW_EN
  logic                            overflow_q, overflow_d;
`endif

  column_adder #(
    .OUT_BIT_LEN(OUT_BIT_LEN),
    .WORD_LEN   (WORD_LEN),
    .CARRY_LEN  (CARRY_LEN)
  ) u_col (
    .cout_i (cout_q[idx_q*OUT_BIT_LEN +: OUT_BIT_LEN]),
    .s_i    (s_q[idx_q*OUT_BIT_LEN +: OUT_BIT_LEN]),
    .carry_i(carry_q),
    .word_o (col_word_s),
    .carry_o(col_carry_s)
  );

  always_comb begin
    state_d = state_q;
    cout_d  = cout_q;
    s_d     = s_q;
    z_d     = z_q;
    carry_d = carry_q;
    idx_d   = idx_q;
`ifdef CARRY_RESOLVE_OVERFLOW_EN
    overflow_d = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cout_d  = Cout;
          s_d     = S;
          carry_d = '0;
          idx_d   = '0;
          state_d = RESOLVE;
        end else begin
          state_d = IDLE;
        end
      end
      RESOLVE: begin
        z_d[idx_q*WORD_LEN +: WORD_LEN] = col_word_s;
        carry_d = col_carry_s;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
`ifdef CARRY_RESOLVE_OVERFLOW_EN
          overflow_d = (col_carry_s != '0);
`endif
        end else begin
          state_d = RESOLVE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef CARRY_RESOLVE_OVERFLOW_EN
          overflow_d = 1'b0;
`endif
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered from the next state so they line up with it.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= '0;
      s_q         <= '0;
      z_q         <= '0;
      carry_q     <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      s_q         <= s_d;
      z_q         <= z_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
    end
  end

`ifdef CARRY_RESOLVE_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_carry_resolve.sv
// Directed self-checking bench for carry_resolve at NUM_ELEMENTS=2
// (4 columns, 19-bit column words, 16-bit output words).
module tb_carry_resolve;

  localparam int NC = 4;
  localparam int OB = 19;
  localparam int WL = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NC*OB-1:0]  cout_v;
  logic [NC*OB-1:0]  s_v;
  logic              out_valid;
  logic              out_ready;
  logic [NC*WL-1:0]  z_v;
  logic              overflow;

  int checks;
  int failures;
  int cyc;
  logic [NC*WL-1:0] z_hold;
  logic exp_ovf;

  carry_resolve #(.NUM_ELEMENTS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Cout     (cout_v),
    .S        (s_v),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (z_v),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present data for one cycle; returns after the accepting edge.
  task automatic send(input logic [NC*OB-1:0] c, input logic [NC*OB-1:0] s);
    cout_v   = c;
    s_v      = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("timeout_out_valid", 80'(out_valid), 80'(1'b1));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cout_v    = '0;
    s_v       = '0;
`ifdef CARRY_RESOLVE_OVERFLOW_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 80'(in_ready), 80'(1'b1));
    chk("rst_out_valid", 80'(out_valid), 80'(1'b0));
    chk("rst_z", 80'(z_v), 80'(0));
    chk("rst_overflow", 80'(overflow), 80'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero product: latency and zero result
    send('0, '0);
    chk("busy_in_ready", 80'(in_ready), 80'(1'b0));
    wait_valid(cyc);
    chk("latency_zero", 80'(cyc), 80'(5));
    chk("z_zero", 80'(z_v), 80'(0));
    chk("ovf_zero", 80'(overflow), 80'(1'b0));
    release_result();
    chk("idle_after_release", 80'(in_ready), 80'(1'b1));

    // Single carry out of column 0
    send({57'h0, 19'h00001}, {57'h0, 19'h0FFFF});
    wait_valid(cyc);
    chk("latency_carry", 80'(cyc), 80'(5));
    chk("z_carry", 80'(z_v), 80'(64'h0000_0000_0001_0000));
    release_result();
    @(negedge clk);

    // All columns at maximum: 2*0x7FFFF per column rippled through
    send({4{19'h7FFFF}}, {4{19'h7FFFF}});
    wait_valid(cyc);
    chk("z_max", 80'(z_v), 80'(64'h000E_000E_000D_FFFE));
    chk("ovf_max", 80'(overflow), 80'(exp_ovf));

    // Hold result under back-pressure while upstream offers a new product
    z_hold   = 64'h000E_000E_000D_FFFE;
    cout_v   = {38'h0, 19'h12345, 19'h0};
    s_v      = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_z", 80'(z_v), 80'(z_hold));
      chk("hold_in_ready", 80'(in_ready), 80'(1'b0));
      chk("hold_out_valid", 80'(out_valid), 80'(1'b1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drop_out_valid", 80'(out_valid), 80'(1'b0));
    chk("drop_in_ready", 80'(in_ready), 80'(1'b1));
    chk("drop_overflow", 80'(overflow), 80'(1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    chk("latency_after_hold", 80'(cyc), 80'(5));
    chk("z_after_hold", 80'(z_v), 80'(64'h0000_0001_2345_0000));
    release_result();
    @(negedge clk);

    // Reset in the middle of RESOLVE (index 2) discards the partial result
    send({57'h0, 19'h00001}, {57'h0, 19'h0FFFF});
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 80'(out_valid), 80'(1'b0));
    chk("midrst_in_ready", 80'(in_ready), 80'(1'b1));
    chk("midrst_z", 80'(z_v), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_z", 80'(z_v), 80'(0));
    chk("postrst_in_ready", 80'(in_ready), 80'(1'b1));
    send({4{19'h7FFFF}}, {4{19'h7FFFF}});
    wait_valid(cyc);
    chk("postrst_z_max", 80'(z_v), 80'(64'h000E_000E_000D_FFFE));
    chk("postrst_ovf", 80'(overflow), 80'(exp_ovf));
    release_result();
    @(negedge clk);

    // Upstream changes right after accept must not affect the result
    send({19'h0, 19'h0, 19'h00002, 19'h0}, {19'h0, 19'h00003, 19'h0, 19'h0});
    cout_v = {4{19'h7FFFF}};
    s_v    = {4{19'h55555}};
    wait_valid(cyc);
    chk("z_capture_only", 80'(z_v), 80'(64'h0000_0003_0002_0000));
    chk("ovf_capture_only", 80'(overflow), 80'(1'b0));
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
